regfile_sequencer: RTL

Initiator for the 8x8 register block. It accepts high-level commands over a valid/ready interface and turns them into the block's write port (we/iaddr/idata) and read port (oe/oaddr/odata) cycles. Read results go back on a valid/ready response channel. It sits between the control logic and the register block, so no client drives the register file pins directly.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_sequencer_if.sv | 44 ++++
 rtl/regfile_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - widths, op encoding and FSM states for regfile_sequencer (REGFILE_SEQ_SWAP_EN adds SW_* states)
package regfile_pkg;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_COPY  = 2'd2,
    OP_SWAP  = 2'd3
  } op_e;

`ifdef REGFILE_SEQ_SWAP_EN
  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD, S_CP_RD, S_CP_WR,
    S_SW_RDA, S_SW_RDB, S_SW_WRA, S_SW_WRB, S_RESP
  } state_e;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD, S_CP_RD, S_CP_WR, S_RESP
  } state_e;
`endif

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - command, response and register-block pins of regfile_sequencer
interface regfile_sequencer_if import regfile_pkg::*; #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src;
  logic [DW-1:0] cmd_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic          rf_we;
  logic [AW-1:0] rf_iaddr;
  logic [DW-1:0] rf_idata;
  logic          rf_oe;
  logic [AW-1:0] rf_oaddr;
  logic [DW-1:0] rf_odata;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output rf_we, rf_iaddr, rf_idata, rf_oe, rf_oaddr,
    input  rf_odata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  rf_we, rf_iaddr, rf_idata, rf_oe, rf_oaddr,
    output rf_odata
  );

endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - command sequencer driving the 8x8 register block (REGFILE_SEQ_SWAP_EN enables SWAP)
module regfile_sequencer import regfile_pkg::*; #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_sequencer_if.master sif,
  output logic                busy
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [DW-1:0] idata_q, idata_d;
  logic          oe_q, oe_d;
  logic [AW-1:0] oaddr_q, oaddr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] tmp_a_q, tmp_a_d;
`ifdef REGFILE_SEQ_SWAP_EN
  logic [AW-1:0] src_q, src_d;
  logic [DW-1:0] tmp_b_q, tmp_b_d;
`endif
  logic          accept;

  assign sif.cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign accept        = sif.cmd_valid && sif.cmd_ready;
  assign busy          = (state_q != S_IDLE);

  assign sif.rf_we     = we_q;
  assign sif.rf_iaddr  = iaddr_q;
  assign sif.rf_idata  = idata_q;
  assign sif.rf_oe     = oe_q;
  assign sif.rf_oaddr  = oaddr_q;
  assign sif.rsp_valid = rsp_valid_q;
  assign sif.rsp_err   = rsp_err_q;
  assign sif.rsp_data  = rsp_data_q;

  // Next state plus the next value of every register-block pin, so the pins come straight from flops
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    iaddr_d     = iaddr_q;
    idata_d     = idata_q;
    oe_d        = oe_q;
    oaddr_d     = oaddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    dst_d       = dst_q;
    tmp_a_d     = tmp_a_q;
`ifdef REGFILE_SEQ_SWAP_EN
    src_d       = src_q;
    tmp_b_d     = tmp_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_e'(sif.cmd_op))
            OP_WRITE: begin
              state_d = S_WR;
              we_d    = 1'b1;
              iaddr_d = sif.cmd_dst;
              idata_d = sif.cmd_data;
            end
            OP_READ: begin
              state_d = S_RD;
              oe_d    = 1'b1;
              oaddr_d = sif.cmd_src;
            end
            OP_COPY: begin
              state_d = S_CP_RD;
              oe_d    = 1'b1;
              oaddr_d = sif.cmd_src;
              dst_d   = sif.cmd_dst;
            end
            OP_SWAP: begin
`ifdef REGFILE_SEQ_SWAP_EN
              state_d = S_SW_RDA;
              oe_d    = 1'b1;
              oaddr_d = sif.cmd_src;
              src_d   = sif.cmd_src;
              dst_d   = sif.cmd_dst;
`else
              // Unsupported op: reject without touching the register block
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      S_RD: begin
        oe_d        = 1'b0;
        rsp_data_d  = sif.rf_odata;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_CP_RD: begin
        // Write data comes from the same read value that lands in tmp_a
        oe_d    = 1'b0;
        tmp_a_d = sif.rf_odata;
        we_d    = 1'b1;
        iaddr_d = dst_q;
        idata_d = sif.rf_odata;
        state_d = S_CP_WR;
      end
      S_CP_WR: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
`ifdef REGFILE_SEQ_SWAP_EN
      S_SW_RDA: begin
        tmp_a_d = sif.rf_odata;
        oaddr_d = dst_q;
        state_d = S_SW_RDB;
      end
      S_SW_RDB: begin
        tmp_b_d = sif.rf_odata;
        oe_d    = 1'b0;
        we_d    = 1'b1;
        iaddr_d = dst_q;
        idata_d = tmp_a_q;
        state_d = S_SW_WRA;
      end
      S_SW_WRA: begin
        iaddr_d = src_q;
        idata_d = tmp_b_q;
        state_d = S_SW_WRB;
      end
      S_SW_WRB: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
`endif
      S_RESP: begin
        if (sif.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        we_d    = 1'b0;
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and all output/temporary flops; async reset may abort a sequence midway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      iaddr_q     <= '0;
      idata_q     <= '0;
      oe_q        <= 1'b0;
      oaddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      dst_q       <= '0;
      tmp_a_q     <= '0;
`ifdef REGFILE_SEQ_SWAP_EN
      src_q       <= '0;
      tmp_b_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      iaddr_q     <= iaddr_d;
      idata_q     <= idata_d;
      oe_q        <= oe_d;
      oaddr_q     <= oaddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      dst_q       <= dst_d;
      tmp_a_q     <= tmp_a_d;
`ifdef REGFILE_SEQ_SWAP_EN
      src_q       <= src_d;
      tmp_b_q     <= tmp_b_d;
`endif
    end
  end

endmodule
